wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the single regfile write port (we/waddr/wdata) between NREQ writeback
//   requesters (ALU, LSU, multi-cycle units) using round-robin arbitration.
//   Keeps a per-register pending scoreboard so issue logic can stall on RAW hazards.
//   Sits between the execute/memory units and the regfile write port.
//   Drives the regfile write port from registered outputs.
// PARAMETERS
//   NREQ   2    number of writeback requesters (2..8)
//   AW     5    register address width (32 architectural registers)
//   DW     32   write data width
// PORTS
//   clk         in   1         clock; all state updates on posedge
//   rst         in   1         asynchronous, active-high reset
//   req_valid   in   NREQ      requester i has a write pending
//   req_ready   out  NREQ      one-hot grant; transfer occurs when valid & ready
//   req_waddr   in   NREQ*AW   packed; requester i's address is at [i*AW +: AW]
//   req_wdata   in   NREQ*DW   packed; requester i's data is at [i*DW +: DW]
//   wb_hold     in   1         when 1, no grant this cycle (e.g. debug freeze)
//   rf_we       out  1         regfile write enable (registered)
//   rf_waddr    out  AW        regfile write address (registered)
//   rf_wdata    out  DW        regfile write data (registered)
//   iss_valid   in   1         an instruction with destination iss_rd is issuing
//   iss_rd      in   AW        destination register of the issuing instruction
//   q_rs1       in   AW        source register query 1
//   q_rs2       in   AW        source register query 2
//   q_busy1     out  1         1 = q_rs1 has an outstanding write (combinational)
//   q_busy2     out  1         1 = q_rs2 has an outstanding write (combinational)
// BEHAVIOUR
//   Reset (async, rst=1)
//     - rf_we=0, rf_waddr=0, rf_wdata=0.
//     - rr_ptr=0; all pending bits = 0.
//     - req_ready=0 while rst is asserted. Any in-flight grant is discarded.
//   Arbitration (combinational, every cycle)
//     - If wb_hold=1 or no req_valid is set, req_ready=0.
//     - Otherwise grant exactly one requester: the first valid index at or after
//       rr_ptr, searching cyclically (rr_ptr, rr_ptr+1, ... mod NREQ).
//     - req_ready is never asserted to a requester whose req_valid is 0.
//     - Requesters must hold valid/waddr/wdata stable until granted.
//   Write-port register (1-cycle latency)
//     - On posedge after a grant to requester i: rf_we=1, and
//       rf_waddr/rf_wdata = requester i's address/data.
//     - On posedge with no grant: rf_we=0; rf_waddr and rf_wdata hold their values.
//     - A granted write with waddr==0 is accepted (ready=1) but produces rf_we=0.
//   Round-robin pointer
//     - After a grant to requester i: rr_ptr <= (i+1) mod NREQ.
//     - With no grant, rr_ptr holds.
//   Scoreboard (pending[1..31]; pending[0] is hardwired to 0)
//     - Set: iss_valid=1 and iss_rd!=0 sets pending[iss_rd] on the posedge.
//     - Clear: rf_we=1 clears pending[rf_waddr] on the posedge (the regfile
//       commits on that same edge).
//     - Set and clear of the same register in the same cycle: set wins
//       (a newer producer has been issued).
//     - q_busyN = pending[q_rsN]; register 0 always reads not busy.
//     - No write forwarding: a register whose write commits this edge still
//       reads busy until the edge.
// TESTING
//   1 Reset mid-op: req0 valid to r5, rst pulsed mid-cycle -> rf_we=0 immediately,
//     pending cleared, no write to r5 after rst is released unless req0 re-asserts.
//   2 Single write: req0 {r3, 0xDEADBEEF} -> ready0=1 in cycle N;
//     cycle N+1: rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF.
//   3 Contention: req0 and req1 valid continuously for 4 cycles, rr_ptr=0 ->
//     grants 0,1,0,1; each writes exactly once per grant.
//   4 x0 write: req1 {r0, 0x12345678} -> ready1=1; next cycle rf_we=0;
//     rr_ptr advances to 0.
//   5 Hold: wb_hold=1 with both valid for 3 cycles -> no ready, rf_we=0;
//     release -> grant goes to rr_ptr.
//   6 Scoreboard: iss r7 -> q_busy=1 for q_rs=7; writeback r7 commits ->
//     busy clears after the edge. Same-cycle re-issue of r7 with commit of r7 ->
//     stays busy. q_rs=0 never busy.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that shares the single regfile write port among NREQ writeback
// requesters and tracks outstanding destination registers for RAW hazard stalls.
module wb_port_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_waddr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic               wb_hold,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_rd,
    input  logic [AW-1:0]      q_rs1,
    input  logic [AW-1:0]      q_rs2,
    output logic               q_busy1,
    output logic               q_busy2
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;

    logic [PW-1:0]   rr_ptr;
    logic            grant_vld_p0;
    logic [PW-1:0]   grant_idx_p0;
    logic [AW-1:0]   sel_waddr_p0;
    logic [DW-1:0]   sel_wdata_p0;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Stage p0: combinational round-robin grant, search starts at rr_ptr and wraps
    always_comb begin
        grant_vld_p0 = 1'b0;
        grant_idx_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_vld_p0 && req_valid[i] && (i >= int'(rr_ptr))) begin
                grant_vld_p0 = 1'b1;
                grant_idx_p0 = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_vld_p0 && req_valid[i] && (i < int'(rr_ptr))) begin
                grant_vld_p0 = 1'b1;
                grant_idx_p0 = PW'(i);
            end
        end
        // A grant presented while reset is high would be lost, so never offer one
        if (rst || wb_hold) begin
            grant_vld_p0 = 1'b0;
        end
    end

    always_comb begin
        req_ready    = '0;
        sel_waddr_p0 = '0;
        sel_wdata_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_vld_p0 && (grant_idx_p0 == PW'(i))) begin
                req_ready[i] = 1'b1;
                sel_waddr_p0 = req_waddr[i*AW +: AW];
                sel_wdata_p0 = req_wdata[i*DW +: DW];
            end
        end
    end

    // Stage p1: registered regfile write port and pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rr_ptr   <= '0;
        end else begin
            rf_we <= 1'b0;
            if (grant_vld_p0) begin
                rr_ptr <= (grant_idx_p0 == PW'(NREQ - 1)) ? '0 : grant_idx_p0 + PW'(1);
                // x0 writes are consumed but never reach the regfile
                if (sel_waddr_p0 != '0) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= sel_waddr_p0;
                    rf_wdata <= sel_wdata_p0;
                end
            end
        end
    end

    // Scoreboard: a fresh issue overrides a commit to the same register
    always_comb begin
        pending_nxt = pending;
        if (rf_we) begin
            pending_nxt[rf_waddr] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            pending_nxt[iss_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign q_busy1 = pending[q_rs1];
    assign q_busy2 = pending[q_rs2];

endmodule
